// File: rtl/input_pack_store_mem_pkg.sv
// ece520_io_pkg: shared widths and the capture FSM state type for the
// input byte-pack / frame-store path.
//   BYTES_PER_WORD  bytes packed into one frame-buffer word
//   WORD_W          frame-buffer word width
//   ADDR_W          frame-buffer address width ({base, word_index})
//   WORD_IDX_W      word index width inside one frame buffer
package ece520_io_pkg;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 16;
  localparam int WORD_W         = 128;
  localparam int ADDR_W         = 16;
  localparam int WORD_IDX_W     = 15;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } store_state_t;
endpackage

// File: rtl/input_pack_store_mem_if.sv
// input_pack_store_mem_if: byte-stream input plus the 128-bit frame-buffer
// write port.
//   DataIn/DataValid        byte source -> store block (no backpressure)
//   WriteAddress/WriteBus/
//   WriteMask/WriteEnable   store block -> frame memory
// Modports: master = store block (drives the memory write port),
//           slave  = byte source / memory side.
interface input_pack_store_mem_if;
  import ece520_io_pkg::*;

  logic [BYTE_W-1:0]         DataIn;
  logic                      DataValid;
  logic [ADDR_W-1:0]         WriteAddress;
  logic [WORD_W-1:0]         WriteBus;
  logic [BYTES_PER_WORD-1:0] WriteMask;
  logic                      WriteEnable;

  modport master (
    input  DataIn, DataValid,
    output WriteAddress, WriteBus, WriteMask, WriteEnable
  );

  modport slave (
    output DataIn, DataValid,
    input  WriteAddress, WriteBus, WriteMask, WriteEnable
  );
endinterface

// File: rtl/input_pack_store_mem_byte_packer.sv
// byte_packer: gathers accepted bytes into a 16-lane accumulator, first byte
// in lane 0 ([7:0]).
//   clock, reset_n  clock / async active-low reset
//   clear           drop any partial word (capture not active)
//   accept          data_in is taken this cycle
//   data_in         input byte
//   word_full       combinational: this accept completes the word
//   word_next       accumulator with this cycle's byte already merged
//   fill_mask       lanes holding valid bytes, including this cycle's byte
module byte_packer
  import ece520_io_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      accept,
  input  logic [BYTE_W-1:0]         data_in,
  output logic                      word_full,
  output logic [WORD_W-1:0]         word_next,
  output logic [BYTES_PER_WORD-1:0] fill_mask
);
  logic [IDX_W-1:0]                           byte_idx;
  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0]      acc;
  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0]      acc_nxt;

  for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_lane
    logic hit;
    assign hit          = accept && (byte_idx == IDX_W'(g));
    assign acc_nxt[g]   = hit ? data_in : acc[g];
    assign fill_mask[g] = hit || (byte_idx > IDX_W'(g));
  end

  assign word_full = accept && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
  assign word_next = acc_nxt;

  // A completed word is handed off the same edge it fills, so the next
  // word's first byte can land in lane 0 on the very next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      byte_idx <= '0;
    end else if (clear || word_full) begin
      acc      <= '0;
      byte_idx <= '0;
    end else if (accept) begin
      acc      <= acc_nxt;
      byte_idx <= byte_idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/input_pack_store_mem.sv
// input_pack_store_mem: packs an incoming byte stream into 128-bit words and
// writes each full word to frame memory at {input_base_offset, word_index}
// with a one-cycle WriteEnable; done rises after the last word of the frame.
//   clock, reset_n     clock / async active-low reset
//   start              level: high = capture frame, low = abort / idle
//   input_base_offset  frame-buffer select, sampled in IDLE only
//   bus (master)       DataIn/DataValid in; WriteAddress/WriteBus/
//                      WriteMask/WriteEnable out
//   done               frame complete (held until start drops)
// Optional feature macro INPUT_STORE_FLUSH_EN: an abort with a partially
// filled word writes that word with a per-byte mask instead of dropping it.
module input_pack_store_mem
  import ece520_io_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 19200
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   input_base_offset,
  input_pack_store_mem_if.master bus,
  output logic                   done
);
  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS_PER_FRAME - 1);

  store_state_t              state, state_nxt;
  logic [WORD_IDX_W-1:0]     word_index;
  logic                      base_q;
  logic                      accept, clear, last_wr, flush, wr_go;
  logic                      word_full;
  logic [WORD_W-1:0]         word_next;
  logic [BYTES_PER_WORD-1:0] fill_mask;

  // Strobe cycle of the frame's final word: the frame is over, so any byte
  // arriving now is not the start of another word.
  assign last_wr = (state == FILL) && bus.WriteEnable && (word_index == LAST_IDX);
  assign accept  = (state == FILL) && bus.DataValid && !last_wr;
  assign clear   = (state != FILL);

  byte_packer u_packer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .accept    (accept),
    .data_in   (bus.DataIn),
    .word_full (word_full),
    .word_next (word_next),
    .fill_mask (fill_mask)
  );

`ifdef INPUT_STORE_FLUSH_EN
  // Abort with bytes held (including one arriving this cycle) and the word
  // not completing: write what we have, unfilled lanes are zero.
  assign flush = (state == FILL) && !start && !word_full && (|fill_mask);
`else
  assign flush = 1'b0;
`endif

  assign wr_go = word_full || flush;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (!start) state_nxt = IDLE;
               else if (last_wr) state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign done = (state == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      word_index       <= '0;
      base_q           <= 1'b0;
      bus.WriteEnable  <= 1'b0;
      bus.WriteAddress <= '0;
      bus.WriteBus     <= '0;
      bus.WriteMask    <= '0;
    end else begin
      state           <= state_nxt;
      bus.WriteEnable <= wr_go;

      // Address advances the cycle after each strobe; the last word pins it.
      if (state == IDLE) begin
        word_index <= '0;
        base_q     <= input_base_offset;
      end else if (state == FILL && bus.WriteEnable && word_index != LAST_IDX) begin
        word_index <= word_index + WORD_IDX_W'(1);
      end

      if (wr_go) begin
        bus.WriteBus     <= word_next;
        bus.WriteAddress <= {base_q, word_index};
        bus.WriteMask    <= word_full ? '1 : fill_mask;
      end else if (state == IDLE) begin
        bus.WriteAddress <= {input_base_offset, {WORD_IDX_W{1'b0}}};
      end
    end
  end
endmodule

// File: tb/tb_input_pack_store_mem.sv
// Bench for input_pack_store_mem: directed frames plus randomized frames.
// A frame-level model (byte queue per word, word counter, done window) pushes
// expected writes into a scoreboard; a negedge monitor pops and compares on
// every WriteEnable and checks done every cycle.
module tb_input_pack_store_mem;
  import ece520_io_pkg::*;

  localparam int WPF   = 4;
  localparam int NEVER = 1 << 30;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic input_base_offset = 1'b0;
  logic done;

  input_pack_store_mem_if bus ();

  input_pack_store_mem #(.WORDS_PER_FRAME(WPF)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .input_base_offset (input_base_offset),
    .bus               (bus.master),
    .done              (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [15:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // frame model
  bit         m_fill = 0;
  bit         m_done = 0;
  logic       m_base = 1'b0;
  int         m_widx = 0;
  logic [7:0] pend[$];
  int         done_on = NEVER;
  int         done_off = NEVER;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic push_word(input int at, input logic [15:0] mask);
    exp_t e;
    e.cyc  = at;
    e.addr = {m_base, 15'(m_widx)};
    e.data = '0;
    foreach (pend[i]) e.data[8*i +: 8] = pend[i];
    e.mask = mask;
    exp_q.push_back(e);
    pend.delete();
  endtask

  // Drive one cycle of inputs and advance the frame model. A byte driven now
  // is captured by the next rising edge; its write shows one cycle later.
  task automatic drive(input bit st, input bit v, input logic [7:0] b, input bit base);
    @(negedge clock);
    start = st; bus.DataValid = v; bus.DataIn = b; input_base_offset = base;
    if (m_fill) begin
      if (v) begin
        pend.push_back(b);
        if (pend.size() == 16) begin
          push_word(cyc + 1, 16'hFFFF);
          if (st) begin
            m_widx++;
            if (m_widx == WPF) begin
              m_fill = 0; m_done = 1; done_on = cyc + 2; done_off = NEVER;
            end
          end
        end
      end
      if (!st) begin
`ifdef INPUT_STORE_FLUSH_EN
        if (pend.size() > 0) push_word(cyc + 1, 16'((1 << pend.size()) - 1));
`endif
        pend.delete();
        m_fill = 0;
      end
    end else if (m_done) begin
      if (!st) begin m_done = 0; done_off = cyc + 1; end
    end else if (st) begin
      m_fill = 1; m_base = base; m_widx = 0; pend.delete();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, 128'(bus.WriteAddress), 128'h0);
    chk({tag, "_bus"},  bus.WriteBus, 128'h0);
    chk({tag, "_mask"}, 128'(bus.WriteMask), 128'h0);
    chk({tag, "_we"},   128'(bus.WriteEnable), 128'h0);
    chk({tag, "_done"}, 128'(done), 128'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    start = 0; bus.DataValid = 0;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    m_fill = 0; m_done = 0; pend.delete(); exp_q.delete();
    done_on = NEVER; done_off = NEVER;
    @(negedge clock);
    #2 reset_n = 1'b1;
  endtask

  // monitor
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.WriteEnable) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe cyc=%0d addr=%h bus=%h mask=%h required no strobe",
                   cyc, bus.WriteAddress, bus.WriteBus, bus.WriteMask);
        end else begin
          mon_e = exp_q.pop_front();
          if (cyc != mon_e.cyc || bus.WriteAddress !== mon_e.addr ||
              bus.WriteBus !== mon_e.data || bus.WriteMask !== mon_e.mask) begin
            fails++;
            $display("FAIL write got cyc=%0d addr=%h bus=%h mask=%h required cyc=%0d addr=%h bus=%h mask=%h",
                     cyc, bus.WriteAddress, bus.WriteBus, bus.WriteMask,
                     mon_e.cyc, mon_e.addr, mon_e.data, mon_e.mask);
          end
        end
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missed_strobe at cyc=%0d addr=%h required by cyc=%0d",
                 cyc, exp_q[0].addr, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      tests++;
      if (done !== (cyc >= done_on && cyc < done_off)) begin
        fails++;
        $display("FAIL done cyc=%0d got=%b required=%b", cyc, done, (cyc >= done_on && cyc < done_off));
      end
    end
  end

  initial begin
    int len;
    bit b;
    bus.DataIn = '0; bus.DataValid = 1'b0;
    #3 check_reset_outputs("reset");
    @(negedge clock);
    #2 reset_n = 1'b1;
    idle(2);

    // 1: 0x00..0x0F, valid held high, base 0
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) drive(1, 1, 8'(i), 0);
    drive(1, 0, 8'h00, 0);
    idle(3);

    // 2: same bytes, valid toggling
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 8'(i), 0);
      drive(1, 0, 8'hEE, 0);
    end
    idle(3);

    // 3: full frame at base 1, extra bytes ignored, base wiggles mid-frame
    drive(1, 0, 8'h00, 1);
    for (int i = 0; i < 84; i++) drive(1, 1, 8'($urandom), 1'($urandom));
    drive(1, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 0);
    idle(3);

    // 4: partial word then abort
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) drive(1, 1, 8'hA1 + 8'(i), 0);
    idle(3);

    // 5: reset after byte 10, then a fresh frame at base 1
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) drive(1, 1, 8'($urandom), 0);
    pulse_reset();
    drive(1, 0, 8'h00, 1);
    for (int i = 0; i < 16; i++) drive(1, 1, 8'($urandom), 1);
    idle(3);

    // 6: 16th byte coincident with start fall
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 15; i++) drive(1, 1, 8'($urandom), 0);
    drive(0, 1, 8'h5A, 0);
    idle(3);

    // random frames: random base, length, gaps and abort byte
    for (int f = 0; f < 10; f++) begin
      b   = 1'($urandom);
      len = $urandom_range(0, 90);
      drive(1, 0, 8'h00, b);
      for (int j = 0; j < len; j++)
        drive(1, ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom));
      drive(0, 1'($urandom), 8'($urandom), 0);
      idle(2);
    end

    idle(3);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
